// File: rtl/tile_map_writer.sv
// Writer side of the tile-type RAM: fills runs of entries with constant or incrementing
// tile codes, or clears the whole map, issuing one registered RAM write per clock.
module tile_map_writer #(
    parameter int unsigned RAM_DATA_WIDTH = 7,
    parameter int unsigned RAM_ADDR_WIDTH = 9,
    parameter int unsigned MAP_SIZE       = 300,
    parameter int unsigned LEN_WIDTH      = 4,
    parameter int unsigned CLEAR_TYPE     = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [RAM_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [RAM_DATA_WIDTH-1:0] req_type_i,
    input  logic [LEN_WIDTH-1:0]      req_len_i,
    input  logic                      req_incr_i,
    input  logic                      clear_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      ram_we_o,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
    output logic [RAM_DATA_WIDTH-1:0] ram_data_o,
    output logic [1:0]                state_o
);

    // Handshake: a request transfers on a rising edge where req_valid_i & req_ready_o;
    // ready is high only in IDLE outside reset, and clear_i takes that slot when both are set.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [RAM_ADDR_WIDTH-1:0] LAST_ADDR  = RAM_ADDR_WIDTH'(MAP_SIZE - 1);
    localparam logic [RAM_DATA_WIDTH-1:0] CLEAR_CODE = RAM_DATA_WIDTH'(CLEAR_TYPE);

    state_t                    state, state_n;
    logic                      we_n, done_n;
    logic [RAM_ADDR_WIDTH-1:0] addr_n, addr_step;
    logic [RAM_DATA_WIDTH-1:0] data_n;
    logic [LEN_WIDTH-1:0]      remain, remain_n;
    logic                      incr_q, incr_n;
    logic                      base_ok;

    assign req_ready_o = (state == IDLE) & ~rst_i;
    assign busy_o      = (state != IDLE);
    assign state_o     = state;
    assign base_ok     = (32'(req_addr_i) < MAP_SIZE);
    assign addr_step   = (ram_addr_o == LAST_ADDR) ? '0 : ram_addr_o + RAM_ADDR_WIDTH'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            ram_we_o   <= 1'b0;
            ram_addr_o <= '0;
            ram_data_o <= '0;
            done_o     <= 1'b0;
            remain     <= '0;
            incr_q     <= 1'b0;
        end else begin
            state      <= state_n;
            ram_we_o   <= we_n;
            ram_addr_o <= addr_n;
            ram_data_o <= data_n;
            done_o     <= done_n;
            remain     <= remain_n;
            incr_q     <= incr_n;
        end
    end

    // The first write of a run/clear is loaded at the accept edge; remain counts writes still owed.
    always_comb begin
        state_n  = state;
        we_n     = 1'b0;
        done_n   = 1'b0;
        addr_n   = ram_addr_o;
        data_n   = ram_data_o;
        remain_n = remain;
        incr_n   = incr_q;
        case (state)
            IDLE: begin
                if (clear_i) begin
                    state_n = CLEAR;
                    we_n    = 1'b1;
                    addr_n  = '0;
                    data_n  = CLEAR_CODE;
                end else if (req_valid_i) begin
                    if ((req_len_i == '0) || !base_ok) begin
                        done_n = 1'b1;
                    end else begin
                        state_n  = RUN;
                        we_n     = 1'b1;
                        addr_n   = req_addr_i;
                        data_n   = req_type_i;
                        remain_n = req_len_i - LEN_WIDTH'(1);
                        incr_n   = req_incr_i;
                    end
                end
            end
            RUN: begin
                if (remain == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    we_n     = 1'b1;
                    addr_n   = addr_step;
                    data_n   = incr_q ? ram_data_o + RAM_DATA_WIDTH'(1) : ram_data_o;
                    remain_n = remain - LEN_WIDTH'(1);
                end
            end
            CLEAR: begin
                if (ram_addr_o == LAST_ADDR) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    we_n   = 1'b1;
                    addr_n = addr_step;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tile_map_writer.sv
// Directed bench for tile_map_writer: runs, wrap, clear priority, no-ops and reset abort.
module tb_tile_map_writer;

    logic       clk;
    logic       rst_i;
    logic       req_valid_i;
    logic       req_ready_o;
    logic [8:0] req_addr_i;
    logic [6:0] req_type_i;
    logic [3:0] req_len_i;
    logic       req_incr_i;
    logic       clear_i;
    logic       busy_o;
    logic       done_o;
    logic       ram_we_o;
    logic [8:0] ram_addr_o;
    logic [6:0] ram_data_o;
    logic [1:0] state_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    tile_map_writer dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_type_i  (req_type_i),
        .req_len_i   (req_len_i),
        .req_incr_i  (req_incr_i),
        .clear_i     (clear_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_data_o  (ram_data_o),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs then belong to the following cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Present a request for one edge (the accept edge T); returns in cycle T+1.
    task automatic send_req(input logic [8:0] a, input logic [6:0] t,
                            input logic [3:0] l, input logic inc);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_type_i  = t;
        req_len_i   = l;
        req_incr_i  = inc;
        check("ready_before_req", 32'(req_ready_o), 1);
        tick();
        req_valid_i = 1'b0;
    endtask

    logic [8:0] wrap_addr [4];
    logic [6:0] code_wrap [2];
    int         good;

    initial begin
        wrap_addr   = '{9'd298, 9'd299, 9'd0, 9'd1};
        code_wrap   = '{7'd127, 7'd0};
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_type_i  = '0;
        req_len_i   = '0;
        req_incr_i  = 1'b0;
        clear_i     = 1'b0;

        // 1: reset
        tick();
        tick();
        check("rst_we", 32'(ram_we_o), 0);
        check("rst_addr", 32'(ram_addr_o), 0);
        check("rst_data", 32'(ram_data_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_ready", 32'(req_ready_o), 0);
        rst_i = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready_o), 1);
        check("post_rst_busy", 32'(busy_o), 0);
        tick();

        // 2: incrementing text run 40/70 x9
        send_req(9'd40, 7'd70, 4'd9, 1'b1);
        for (int k = 0; k < 9; k++) begin
            check("txt_we", 32'(ram_we_o), 1);
            check("txt_addr", 32'(ram_addr_o), 32'(40 + k));
            check("txt_data", 32'(ram_data_o), 32'(70 + k));
            check("txt_no_done", 32'(done_o), 0);
            check("txt_busy", 32'(busy_o), 1);
            tick();
        end
        check("txt_end_we", 32'(ram_we_o), 0);
        check("txt_done", 32'(done_o), 1);
        check("txt_ready", 32'(req_ready_o), 1);
        tick();
        check("txt_done_pulse", 32'(done_o), 0);

        // 3: address wrap, then code wrap
        send_req(9'd298, 7'd2, 4'd4, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("wrap_we", 32'(ram_we_o), 1);
            check("wrap_addr", 32'(ram_addr_o), 32'(wrap_addr[k]));
            check("wrap_data", 32'(ram_data_o), 2);
            tick();
        end
        check("wrap_done", 32'(done_o), 1);
        send_req(9'd5, 7'd127, 4'd2, 1'b1);
        for (int k = 0; k < 2; k++) begin
            check("cwrap_addr", 32'(ram_addr_o), 32'(5 + k));
            check("cwrap_data", 32'(ram_data_o), 32'(code_wrap[k]));
            tick();
        end
        check("cwrap_done", 32'(done_o), 1);
        check("cwrap_we", 32'(ram_we_o), 0);

        // 4: clear beats a simultaneous request; request held and taken at T+301
        clear_i     = 1'b1;
        req_valid_i = 1'b1;
        req_addr_i  = 9'd10;
        req_type_i  = 7'd5;
        req_len_i   = 4'd2;
        req_incr_i  = 1'b1;
        tick();
        clear_i = 1'b0;
        check("clr_busy", 32'(busy_o), 1);
        check("clr_ready", 32'(req_ready_o), 0);
        good = 0;
        for (int i = 0; i < 300; i++) begin
            if (ram_we_o === 1'b1 && ram_addr_o === 9'(i) && ram_data_o === 7'd0 && done_o === 1'b0)
                good++;
            tick();
        end
        check("clr_good_writes", 32'(good), 300);
        check("clr_done", 32'(done_o), 1);
        check("clr_end_we", 32'(ram_we_o), 0);
        check("clr_ready_end", 32'(req_ready_o), 1);
        tick();
        req_valid_i = 1'b0;
        check("held_we", 32'(ram_we_o), 1);
        check("held_addr", 32'(ram_addr_o), 10);
        check("held_data", 32'(ram_data_o), 5);
        tick();
        check("held_addr1", 32'(ram_addr_o), 11);
        check("held_data1", 32'(ram_data_o), 6);
        tick();
        check("held_done", 32'(done_o), 1);
        tick();

        // 5: zero length and out-of-map base
        send_req(9'd20, 7'd9, 4'd0, 1'b0);
        check("len0_we", 32'(ram_we_o), 0);
        check("len0_done", 32'(done_o), 1);
        check("len0_busy", 32'(busy_o), 0);
        check("len0_addr_hold", 32'(ram_addr_o), 11);
        check("len0_data_hold", 32'(ram_data_o), 6);
        send_req(9'd310, 7'd9, 4'd3, 1'b0);
        check("oob_we", 32'(ram_we_o), 0);
        check("oob_done", 32'(done_o), 1);
        check("oob_busy", 32'(busy_o), 0);
        tick();
        check("oob_we_after", 32'(ram_we_o), 0);
        check("oob_done_after", 32'(done_o), 0);

        // 6: reset mid-run at T+4
        send_req(9'd100, 7'd3, 4'd9, 1'b0);
        tick();
        tick();
        tick();
        check("abort_pre_addr", 32'(ram_addr_o), 103);
        rst_i = 1'b1;
        #1;
        check("abort_ready_in_rst", 32'(req_ready_o), 0);
        tick();
        check("abort_we", 32'(ram_we_o), 0);
        check("abort_done", 32'(done_o), 0);
        rst_i = 1'b0;
        good = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ram_we_o === 1'b0 && done_o === 1'b0) good++;
        end
        check("abort_quiet", 32'(good), 8);
        check("abort_state", 32'(state_o), 0);
        check("abort_busy", 32'(busy_o), 0);
        check("abort_ready", 32'(req_ready_o), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
